// File: rtl/playback_time_display_pkg.sv
// Shared constants and BCD helpers for the playback time display.
// Holds the register map, CONTROL/STATUS bit positions, active-low
// 7-segment codes ({g..a}) and the mm:ss BCD validate/increment helpers.
package playback_time_display_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_TIME   = 2'd1;
    localparam logic [1:0] ADDR_MS     = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CONTROL bits
    localparam int unsigned CTRL_RUN   = 0;
    localparam int unsigned CTRL_CLEAR = 1;
    localparam int unsigned CTRL_BLANK = 2;

    // STATUS bits
    localparam int unsigned STAT_WRAPPED    = 0;
    localparam int unsigned STAT_PRESET_ERR = 1;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = SEG_0;

    // Largest representable time; advancing past it wraps to 00:00.
    localparam logic [15:0] TIME_MAX = 16'h9959;

    // A preset is legal only if every nibble is a decimal digit and
    // the seconds-tens digit is 0..5.
    function automatic logic bcd_time_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // Advance mm:ss by one second with BCD carries; 99:59 rolls to 00:00.
    function automatic logic [15:0] bcd_time_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    r[15:12] = (t[15:12] != 4'd9) ? t[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   bcd_i - 4-bit BCD digit
//   seg_o - segments {g..a}, active-low; non-decimal input shows blank
module bcd_to_seg7
    import playback_time_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/playback_time_display.sv
// Elapsed playback time (mm:ss BCD) driven by an external tick, shown on four
// 7-segment digits and controlled through a small Avalon-MM slave.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   tick_in           - timer timeout (pulse or level), counted on rising edge
//   address, chipselect, write_n, writedata - Avalon-MM write/select
//   readdata          - registered read data (valid 1 cycle after address)
//   hex0..hex3        - sec ones, sec tens, min ones, min tens (active-low)
module playback_time_display
    import playback_time_display_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned MS_W          = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    logic            tick_q;
    logic [MS_W-1:0] ms_q, ms_d;
    logic [15:0]     time_q, time_d;
    logic            run_q, run_d;
    logic            blank_q, blank_d;
    logic            wrapped_q, wrapped_d;
    logic            perr_q, perr_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [6:0]      hex0_q, hex1_q, hex2_q, hex3_q;
    logic [6:0]      seg0, seg1, seg2, seg3;

    logic wr, ctrl_wr, time_wr, stat_wr, clear, tick_rise, count, ms_last;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr & (address == ADDR_CTRL);
    assign time_wr   = wr & (address == ADDR_TIME);
    assign stat_wr   = wr & (address == ADDR_STATUS);
    assign clear     = ctrl_wr & writedata[CTRL_CLEAR];
    assign tick_rise = tick_in & ~tick_q;
    // run_q, not the incoming write, gates counting this cycle
    assign count     = run_q & tick_rise;
    assign ms_last   = (ms_q == MS_W'(TICKS_PER_SEC - 1));

    // Time/ms next state: clear > TIME write > tick
    always_comb begin
        time_d    = time_q;
        ms_d      = ms_q;
        wrapped_d = wrapped_q;
        perr_d    = perr_q;
        run_d     = run_q;
        blank_d   = blank_q;

        if (ctrl_wr) begin
            run_d   = writedata[CTRL_RUN];
            blank_d = writedata[CTRL_BLANK];
        end

        // Sticky-bit clears first so a coincident set below overrides them
        if (stat_wr && writedata[STAT_WRAPPED]) begin
            wrapped_d = 1'b0;
        end
        if (stat_wr && writedata[STAT_PRESET_ERR]) begin
            perr_d = 1'b0;
        end

        if (clear) begin
            time_d = '0;
            ms_d   = '0;
        end else if (time_wr) begin
            if (bcd_time_valid(writedata)) begin
                time_d = writedata;
                ms_d   = '0;
            end else begin
                perr_d = 1'b1;
            end
        end else if (count) begin
            if (ms_last) begin
                ms_d   = '0;
                time_d = bcd_time_inc(time_q);
                if (time_q == TIME_MAX) begin
                    wrapped_d = 1'b1;
                end
            end else begin
                ms_d = ms_q + 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_CTRL: begin
                rdata_d[CTRL_RUN]   = run_q;
                rdata_d[CTRL_BLANK] = blank_q;
            end
            ADDR_TIME: rdata_d = time_q;
            ADDR_MS:   rdata_d = 16'(ms_q);
            default: begin
                rdata_d[STAT_WRAPPED]    = wrapped_q;
                rdata_d[STAT_PRESET_ERR] = perr_q;
            end
        endcase
    end

    bcd_to_seg7 u_seg0 (.bcd_i(time_q[3:0]),   .seg_o(seg0));
    bcd_to_seg7 u_seg1 (.bcd_i(time_q[7:4]),   .seg_o(seg1));
    bcd_to_seg7 u_seg2 (.bcd_i(time_q[11:8]),  .seg_o(seg2));
    bcd_to_seg7 u_seg3 (.bcd_i(time_q[15:12]), .seg_o(seg3));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q    <= 1'b0;
            ms_q      <= '0;
            time_q    <= '0;
            run_q     <= 1'b0;
            blank_q   <= 1'b0;
            wrapped_q <= 1'b0;
            perr_q    <= 1'b0;
            rdata_q   <= '0;
            hex0_q    <= SEG_ZERO;
            hex1_q    <= SEG_ZERO;
            hex2_q    <= SEG_ZERO;
            hex3_q    <= SEG_ZERO;
        end else begin
            tick_q    <= tick_in;
            ms_q      <= ms_d;
            time_q    <= time_d;
            run_q     <= run_d;
            blank_q   <= blank_d;
            wrapped_q <= wrapped_d;
            perr_q    <= perr_d;
            rdata_q   <= rdata_d;
            hex0_q    <= blank_q ? SEG_BLANK : seg0;
            hex1_q    <= blank_q ? SEG_BLANK : seg1;
            hex2_q    <= blank_q ? SEG_BLANK : seg2;
            hex3_q    <= blank_q ? SEG_BLANK : seg3;
        end
    end

    assign readdata = rdata_q;
    assign hex0     = hex0_q;
    assign hex1     = hex1_q;
    assign hex2     = hex2_q;
    assign hex3     = hex3_q;

endmodule

// File: tb/tb_playback_time_display.sv
module tb_playback_time_display;

    logic        clk;
    logic        reset_n;
    logic        tick_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [6:0]  hex0, hex1, hex2, hex3;

    playback_time_display #(.TICKS_PER_SEC(1000), .MS_W(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_in    (tick_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: elapsed time as plain seconds plus sub-second ticks
    int m_secs, m_ms;
    bit m_run, m_blank, m_wrapped, m_perr;

    typedef struct {
        logic [15:0] preset;
        int          ticks;
        logic [15:0] exp_time;
        logic [15:0] exp_ms;
        logic [27:0] exp_hex;  // {hex3,hex2,hex1,hex0}
        logic [15:0] exp_status;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_ms = 0; m_run = 0; m_blank = 0; m_wrapped = 0; m_perr = 0;
    endtask

    task automatic model_tick();
        if (m_run) begin
            m_ms++;
            if (m_ms == 1000) begin
                m_ms = 0;
                m_secs++;
                if (m_secs == 6000) begin
                    m_secs = 0;
                    m_wrapped = 1;
                end
            end
        end
    endtask

    task automatic model_write(input logic [1:0] a, input logic [15:0] d);
        int n3, n2, n1, n0;
        case (a)
            2'd0: begin
                if (d[1]) begin m_secs = 0; m_ms = 0; end
                m_run = d[0];
                m_blank = d[2];
            end
            2'd1: begin
                n3 = int'(d[15:12]); n2 = int'(d[11:8]); n1 = int'(d[7:4]); n0 = int'(d[3:0]);
                if (n3 > 9 || n2 > 9 || n1 > 5 || n0 > 9) m_perr = 1;
                else begin
                    m_secs = (n3 * 10 + n2) * 60 + n1 * 10 + n0;
                    m_ms = 0;
                end
            end
            2'd3: begin
                if (d[0]) m_wrapped = 0;
                if (d[1]) m_perr = 0;
            end
            default: ;
        endcase
    endtask

    // All tasks start and end at posedge+1
    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        model_write(a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic tick_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            @(posedge clk); #1;
            tick_in = 1'b0;
            @(posedge clk); #1;
            model_tick();
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] d, t;
        t = to_bcd(m_secs);
        bus_read(2'd1, d); check({tag, ".time"}, d, t);
        bus_read(2'd2, d); check({tag, ".ms"}, d, 16'(m_ms));
        bus_read(2'd3, d); check({tag, ".status"}, d, {14'b0, m_perr, m_wrapped});
        bus_read(2'd0, d); check({tag, ".ctrl"}, d, {13'b0, m_blank, 1'b0, m_run});
        check({tag, ".hex0"}, {9'b0, hex0}, {9'b0, m_blank ? 7'h7F : seg_of(int'(t[3:0]))});
        check({tag, ".hex1"}, {9'b0, hex1}, {9'b0, m_blank ? 7'h7F : seg_of(int'(t[7:4]))});
        check({tag, ".hex2"}, {9'b0, hex2}, {9'b0, m_blank ? 7'h7F : seg_of(int'(t[11:8]))});
        check({tag, ".hex3"}, {9'b0, hex3}, {9'b0, m_blank ? 7'h7F : seg_of(int'(t[15:12]))});
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] ms_before;
        int op, n;

        vecs[0] = '{16'h0000, 1000, 16'h0001, 16'd0,   {7'h40, 7'h40, 7'h40, 7'h79}, 16'h0000};
        vecs[1] = '{16'h0959, 1000, 16'h1000, 16'd0,   {7'h79, 7'h40, 7'h40, 7'h40}, 16'h0000};
        vecs[2] = '{16'h9959, 1000, 16'h0000, 16'd0,   {7'h40, 7'h40, 7'h40, 7'h40}, 16'h0001};
        vecs[3] = '{16'h0509, 1000, 16'h0510, 16'd0,   {7'h40, 7'h12, 7'h79, 7'h40}, 16'h0000};
        vecs[4] = '{16'h5959, 1500, 16'h6000, 16'd500, {7'h02, 7'h40, 7'h40, 7'h40}, 16'h0000};
        vecs[5] = '{16'h0000, 999,  16'h0000, 16'd999, {7'h40, 7'h40, 7'h40, 7'h40}, 16'h0000};

        tick_in = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        reset_n = 1'b1;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.hex0", {9'b0, hex0}, 16'h0040);
        check("rst.hex3", {9'b0, hex3}, 16'h0040);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_all("rst");

        // Table: preset, run, tick, stop, compare against hand-derived values
        foreach (vecs[i]) begin
            bus_write(2'd0, 16'h0002);
            bus_write(2'd3, 16'h0003);
            check_all($sformatf("vec%0d.pre", i));
            bus_write(2'd1, vecs[i].preset);
            bus_write(2'd0, 16'h0001);
            tick_pulses(vecs[i].ticks);
            bus_write(2'd0, 16'h0000);
            bus_read(2'd1, d); check($sformatf("vec%0d.time", i), d, vecs[i].exp_time);
            bus_read(2'd2, d); check($sformatf("vec%0d.ms", i), d, vecs[i].exp_ms);
            bus_read(2'd3, d); check($sformatf("vec%0d.status", i), d, vecs[i].exp_status);
            check($sformatf("vec%0d.hex", i), {hex3[3:0], hex2[3:0], hex1[3:0], hex0[3:0]},
                  {vecs[i].exp_hex[24:21], vecs[i].exp_hex[17:14],
                   vecs[i].exp_hex[10:7], vecs[i].exp_hex[3:0]});
            check($sformatf("vec%0d.hexhi", i),
                  {4'b0, hex3[6:4], hex2[6:4], hex1[6:4], hex0[6:4]},
                  {4'b0, vecs[i].exp_hex[27:25], vecs[i].exp_hex[20:18],
                   vecs[i].exp_hex[13:11], vecs[i].exp_hex[6:4]});
            check_all($sformatf("vec%0d.model", i));
        end

        // Wrapped flag is cleared by writing 1
        bus_write(2'd1, 16'h9959);
        bus_write(2'd0, 16'h0001);
        tick_pulses(1000);
        bus_read(2'd3, d); check("wrap.set", d, 16'h0001);
        bus_write(2'd3, 16'h0001);
        bus_read(2'd3, d); check("wrap.clr", d, 16'h0000);

        // Invalid presets leave time untouched and set preset_err
        bus_write(2'd1, 16'h0123);
        bus_write(2'd1, 16'h0A00);
        bus_read(2'd1, d); check("perr.nib", d, 16'h0123);
        bus_write(2'd1, 16'h0060);
        bus_read(2'd1, d); check("perr.st", d, 16'h0123);
        bus_read(2'd3, d); check("perr.flag", d, 16'h0002);
        bus_write(2'd3, 16'h0002);
        bus_read(2'd3, d); check("perr.clr", d, 16'h0000);
        check_all("perr");

        // Level held 5 cycles counts once
        tick_pulses(3);
        bus_read(2'd2, ms_before);
        tick_in = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        tick_in = 1'b0;
        @(posedge clk); #1;
        model_tick();
        bus_read(2'd2, d); check("level.ms", d, ms_before + 16'd1);

        // Clear coinciding with a tick edge: tick dropped
        address = 2'd0; writedata = 16'h0003; chipselect = 1'b1; write_n = 1'b0; tick_in = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; tick_in = 1'b0;
        model_write(2'd0, 16'h0003);
        bus_read(2'd2, d); check("clrtick.ms", d, 16'h0000);
        bus_read(2'd1, d); check("clrtick.time", d, 16'h0000);

        // Writing run=0 with a simultaneous tick: tick still counted
        tick_pulses(2);
        address = 2'd0; writedata = 16'h0000; chipselect = 1'b1; write_n = 1'b0; tick_in = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; tick_in = 1'b0;
        model_tick();
        model_write(2'd0, 16'h0000);
        bus_read(2'd2, d); check("stoptick.ms", d, 16'h0003);

        // Writing run=1 with a simultaneous tick: not counted yet
        address = 2'd0; writedata = 16'h0001; chipselect = 1'b1; write_n = 1'b0; tick_in = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; tick_in = 1'b0;
        model_write(2'd0, 16'h0001);
        bus_read(2'd2, d); check("starttick.ms", d, 16'h0003);

        // Pause: 50 ticks ignored
        bus_write(2'd0, 16'h0000);
        tick_pulses(50);
        bus_read(2'd2, d); check("pause.ms", d, 16'h0003);
        check_all("pause");

        // Blank
        bus_write(2'd0, 16'h0004);
        check_all("blank");

        // Randomised sequence against the model
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    if ($urandom_range(0, 2) == 0) bus_write(2'd1, 16'($urandom()));
                    else bus_write(2'd1, to_bcd($urandom_range(0, 1) == 0 ?
                                                $urandom_range(5990, 5999) :
                                                $urandom_range(0, 5999)));
                end
                1: begin
                    d = 16'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
                    if ($urandom_range(0, 2) != 0) d[0] = 1'b1;
                    bus_write(2'd0, d);
                end
                2: begin
                    n = $urandom_range(0, 40);
                    if ($urandom_range(0, 3) == 0) n += 1000;
                    tick_pulses(n);
                end
                3: bus_write(2'd3, 16'($urandom_range(0, 3)));
                default: check_all($sformatf("rnd%0d", it));
            endcase
        end
        check_all("rnd.end");

        // Asynchronous reset mid-count
        bus_write(2'd1, 16'h1234);
        bus_write(2'd0, 16'h0001);
        tick_pulses(7);
        tick_in = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("midrst.hex0", {9'b0, hex0}, 16'h0040);
        check("midrst.hex2", {9'b0, hex2}, 16'h0040);
        tick_in = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        check_all("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/playback_time_display.md
Name: playback_time_display

Overview:
- Downstream consumer of the 1 ms interval timer. Takes the timer's timeout pulse (or its irq level) as a tick input.
- Accumulates elapsed playback time as mm:ss in BCD.
- Drives four 7-segment digits.
- Exposes an Avalon-MM slave (16-bit data, 1-cycle registered read) for software run/pause/clear/preset and time readback.

Parameters:
- TICKS_PER_SEC, 1000, tick edges per second increment (1 ms timer -> 1000).
- MS_W, 10, width of the sub-second tick counter; must satisfy 2**MS_W >= TICKS_PER_SEC.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick_in  in  1  timer timeout, pulse or level; counted on its rising edge only
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- hex0  out  7  seconds ones, segments {g..a}, active-low
- hex1  out  7  seconds tens
- hex2  out  7  minutes ones
- hex3  out  7  minutes tens

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low.
- Reset values:
  - time = 0x0000; ms_cnt = 0; run = 0; blank = 0; status = 0; readdata = 0.
  - hex0..hex3 = 7'h40 (digit "0"); tick edge register = 0.
- Tick edge detect: tick_d registers tick_in; tick_rise = tick_in & ~tick_d. A level held N cycles counts once.
- Registers (wr = chipselect & ~write_n):
  - addr0 CONTROL:
    - bit0 run (R/W).
    - bit1 clear: write-only pulse, reads 0; zeroes time and ms_cnt.
    - bit2 blank (R/W): all hex outputs = 7'h7F.
  - addr1 TIME:
    - Read: {min_tens, min_ones, sec_tens, sec_ones} BCD.
    - Write: presets time and zeroes ms_cnt.
  - addr2 MS: read ms_cnt zero-extended; writes ignored.
  - addr3 STATUS:
    - bit0 wrapped (sticky); bit1 preset_err (sticky).
    - Write 1 to a bit clears it; write 0 has no effect.
- Counting (run = 1 and tick_rise):
  - If ms_cnt == TICKS_PER_SEC-1: ms_cnt <= 0 and time advances by one second. Otherwise ms_cnt <= ms_cnt+1.
  - Second advance is BCD with carries: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens.
  - 99:59 -> 00:00 and sets wrapped.
- Pause: with run = 0, ticks are ignored, time and ms_cnt hold, and the tick edge register still updates.
- Preset validation:
  - Any nibble > 9, or sec_tens > 5: the whole write is ignored, preset_err <= 1, time and ms_cnt unchanged.
  - A valid write takes effect on the next clock.
- Simultaneous-event priority: clear > TIME write > tick.
  - A tick coinciding with a clear or TIME write is dropped.
  - A STATUS clear coinciding with a wrap event leaves wrapped = 1 (set wins).
- Run-bit timing:
  - CONTROL write setting run: ticks are counted from the next cycle.
  - CONTROL write with run = 0 and a simultaneous tick: the tick is counted, because run is the current register value.
- Read: readdata <= mux(address) every cycle; data valid 1 cycle after address is presented. Unused bits read 0.
- Display:
  - hex outputs are registered from the BCD value after decoding, so they lag a time update by 1 cycle.
  - blank is applied in the same register.
- Mid-operation reset: immediate async return to reset values; a pending tick edge is lost.

Decomposition:
- Shared package holds:
  - register address constants (CTRL = 0, TIME = 1, MS = 2, STATUS = 3);
  - CONTROL/STATUS bit index constants;
  - segment codes for 0-9 plus SEG_BLANK = 7'h7F and SEG_ZERO = 7'h40.
- One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out; invalid input gives SEG_BLANK), instantiated four times.

Test Plan:
- Reset: assert reset_n = 0 mid-count -> hex0..3 = 7'h40, TIME reads 0x0000, STATUS reads 0x0000, CONTROL reads 0x0000.
- Run: write CONTROL = 0x0001, then 1000 single-cycle tick_in pulses -> TIME = 0x0001, MS = 0, hex0 = 7'h79 ("1").
- Carry: preset TIME = 0x0959, run, 1000 ticks -> TIME = 0x1000; hex3 = 7'h79, hex2/hex1/hex0 = 7'h40.
- Wrap: preset 0x9959, run, 1000 ticks -> TIME = 0x0000, STATUS bit0 = 1. Write STATUS = 0x0001 -> STATUS = 0.
- Invalid preset: write TIME = 0x0A00, then 0x0060 -> time unchanged both times, STATUS bit1 = 1. Write STATUS = 0x0002 -> bit1 = 0.
- Edge/priority:
  - tick_in held high 5 cycles -> MS increments by exactly 1.
  - CONTROL clear pulse coinciding with tick_rise -> MS = 0, TIME = 0x0000.
  - Pause with run = 0 -> 50 ticks leave MS unchanged.
